// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor: counter states, MODE values, update ops.
// Also holds a saturating 32-bit increment used by the statistics counters.
package branch_predictor_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    localparam int MODE_STATIC  = 0;
    localparam int MODE_BIMODAL = 1;

    typedef enum logic [2:0] {
        BR_NONE  = 3'd0,
        BR_INC   = 3'd1,
        BR_ALLOC = 3'd2,
        BR_DEC   = 3'd3,
        BR_CLEAR = 3'd4
    } br_op_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
        return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_cnt2.sv
// 2-bit saturating counter next-state; combinational, no backpressure.
// inc and dec together leave the counter unchanged.
module sat_cnt2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] counter_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] next_o
);

    always_comb begin
        next_o = counter_i;
        if (inc_i && !dec_i && (counter_i != CNT_ST)) begin
            next_o = counter_i + 2'd1;
        end else if (dec_i && !inc_i && (counter_i != CNT_SNT)) begin
            next_o = counter_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal predictor with direct-mapped BTB; zero-cycle lookup, one-cycle update.
// No backpressure: one resolution accepted every cycle.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 16,
    parameter int         MODE     = 1,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_branch,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     miss_cnt
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic            valid_q [ENTRIES];
    logic [TAGW-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0] tgt_q   [ENTRIES];
    logic [1:0]      cnt_q   [ENTRIES];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    logic [IDX-1:0]  if_idx, upd_idx;
    logic [TAGW-1:0] if_tag, upd_tag;
    logic            lookup_hit, upd_hit;
    br_op_e          op_d;
    logic [1:0]      cnt_next;
    logic            unused_pc_bits;

    assign if_idx  = if_pc[IDX+1:2];
    assign if_tag  = if_pc[XLEN-1:IDX+2];
    assign upd_idx = upd_pc[IDX+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX+2];
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    assign lookup_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign pred_taken  = (MODE == MODE_BIMODAL) && reset && lookup_hit && cnt_q[if_idx][1];
    assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + XLEN'(4);

    assign mispredict  = reset && upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

    // A non-branch that hits means an aliased PC; drop the stale entry.
    always_comb begin
        op_d = BR_NONE;
        if ((MODE == MODE_BIMODAL) && upd_valid) begin
            if (!upd_is_branch) begin
                op_d = upd_hit ? BR_CLEAR : BR_NONE;
            end else if (upd_taken) begin
                op_d = upd_hit ? BR_INC : BR_ALLOC;
            end else begin
                op_d = upd_hit ? BR_DEC : BR_NONE;
            end
        end
    end

    sat_cnt2 u_sat_cnt2 (
        .counter_i (cnt_q[upd_idx]),
        .inc_i     (op_d == BR_INC),
        .dec_i     (op_d == BR_DEC),
        .next_o    (cnt_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_INIT;
            end
        end else begin
            case (op_d)
                BR_INC: begin
                    cnt_q[upd_idx] <= cnt_next;
                    tgt_q[upd_idx] <= upd_target;
                end
                BR_ALLOC: begin
                    valid_q[upd_idx] <= 1'b1;
                    tag_q[upd_idx]   <= upd_tag;
                    tgt_q[upd_idx]   <= upd_target;
                    cnt_q[upd_idx]   <= CNT_WT;
                end
                BR_DEC:   cnt_q[upd_idx]   <= cnt_next;
                BR_CLEAR: valid_q[upd_idx] <= 1'b0;
                default:  ;
            endcase
        end
    end

    assign branch_cnt_d = sat_inc32(branch_cnt_q, upd_valid && upd_is_branch);
    assign miss_cnt_d   = sat_inc32(miss_cnt_q, mispredict);

    always_ff @(posedge clk) begin
        if (!reset) begin
            branch_cnt_q <= 32'd0;
            miss_cnt_q   <= 32'd0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter XLEN, default 32, datapath and address width.
REQ-002 Parameter ENTRIES, default 16, table depth; power of two, at least 2; IDX = log2(ENTRIES).
REQ-003 Parameter MODE, default 1, 0 = static not-taken, 1 = dynamic 2-bit bimodal with BTB.
REQ-004 Parameter CNT_INIT, default 2'b01, counter value written on reset.
REQ-005 clk  in  1  rising-edge clock, single clock domain.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 if_pc  in  XLEN  fetch-stage PC to predict.
REQ-008 pred_taken  out  1  prediction for if_pc, combinational.
REQ-009 pred_target  out  XLEN  next fetch PC for if_pc, combinational.
REQ-010 upd_valid  in  1  EX-stage resolution valid this cycle.
REQ-011 upd_pc  in  XLEN  PC of the resolving instruction.
REQ-012 upd_is_branch  in  1  resolving instruction is a conditional branch or JAL.
REQ-013 upd_taken  in  1  actual outcome; 0 for non-branches.
REQ-014 upd_target  in  XLEN  actual target when taken.
REQ-015 upd_pred_taken  in  1  prediction made for this instruction, piped from IF.
REQ-016 upd_pred_target  in  XLEN  target predicted for this instruction, piped from IF.
REQ-017 mispredict  out  1  flush request, combinational from upd_* inputs.
REQ-018 redirect_pc  out  XLEN  correct next PC on mispredict.
REQ-019 branch_cnt  out  32  resolved-branch count, registered.
REQ-020 miss_cnt  out  32  mispredict count, registered.

Function
REQ-021 Each entry holds valid, tag, target and a 2-bit counter.
REQ-022 Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
REQ-023 Hit means the indexed entry is valid and its tag equals the tag of if_pc.
REQ-024 MODE=1: pred_taken = hit & cnt[1]. MODE=0: pred_taken = 0.
REQ-025 pred_target = entry target when pred_taken = 1, otherwise if_pc+4 (modulo 2^XLEN).
REQ-026 mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
REQ-027 redirect_pc = upd_target when upd_taken = 1, otherwise upd_pc+4.
REQ-028 Taken branch, table hit: counter saturating-increments (11 holds at 11) and target is overwritten.
REQ-029 Taken branch, table miss: the entry is allocated with valid=1, the new tag, upd_target and cnt=2'b10.
REQ-030 Not-taken branch, table hit: counter saturating-decrements (00 holds at 00).
REQ-031 Not-taken branch, table miss: no change.
REQ-032 Non-branch update (upd_valid & !upd_is_branch) that hits the table clears that entry's valid bit (alias cleanup).
REQ-033 MODE=0: the table is never written; mispredict, redirect_pc and the counters still operate.
REQ-034 All table writes take effect at the clock edge; a same-cycle lookup of the index being updated returns pre-update contents.
REQ-035 branch_cnt increments on upd_valid & upd_is_branch.
REQ-036 miss_cnt increments on mispredict.
REQ-037 Both counters saturate at 32'hFFFF_FFFF.
REQ-038 Lookup has zero-cycle latency; update latency is one cycle.

Reset
REQ-039 While reset=0 at a clock edge: all valid bits clear, all counters load CNT_INIT, branch_cnt = 0 and miss_cnt = 0.
REQ-040 While reset=0: pred_taken = 0, mispredict = 0, and upd_* inputs are ignored.
REQ-041 Reset asserted mid-operation discards any in-flight update; no partial entry write occurs.

Structure
REQ-042 Counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the MODE constants belong in the shared defines header, alongside the BR_* codes.
REQ-043 The 2-bit saturating counter is a sub-module named sat_cnt2 (inputs: counter, inc, dec; output: next value).
REQ-044 Table storage is flop-based and uses no memory macro.

Verification
REQ-045 After reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104, branch_cnt=0, miss_cnt=0.
REQ-046 Update pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80; miss_cnt=1.
REQ-047 Three not-taken updates at 0x100 after REQ-046 -> counter 10->01->00->00; pred_taken=0 after the first; branch_cnt=4.
REQ-048 ENTRIES=16, entry at 0x100 valid, if_pc=0x140 (same index, different tag) -> pred_taken=0, pred_target=0x144.
REQ-049 Taken update at 0x200 and lookup at 0x200 in the same cycle -> lookup pred_taken=0; the following cycle pred_taken=1.
REQ-050 MODE=0, taken update at 0x100, target 0x80 -> pred_taken stays 0, mispredict=1, redirect_pc=0x80; reset=0 mid-sequence -> counters return to 0.
